ppi_lane_scheduler: RTL
=======================

PPI_LANE_SCHEDULER -- requirements
Module: ppi_lane_scheduler

Interface
REQ-001 SHALL have parameter PREP_CYCLES, default 3: number of cycles in PREP before the first beat is accepted (range 1..15).
REQ-002 SHALL have port ppi_clk, input, 1: the only clock; all logic on its rising edge.
REQ-003 SHALL have port ppi_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cfg_lane_cnt, input, 2: number of active lanes minus 1 (N = cfg_lane_cnt+1).
REQ-005 SHALL have port pkt_valid, input, 1: a packet-layer beat is offered.
REQ-006 SHALL have port pkt_data, input, 32: beat bytes; byte k (bits 8k+7:8k) goes to lane k.
REQ-007 SHALL have port pkt_nbytes, input, 3: valid bytes in the beat, 1..N; only lanes 0..nbytes-1 carry data.
REQ-008 SHALL have port pkt_last, input, 1: the beat is the final beat of its packet.
REQ-009 SHALL have port pkt_ready, output, 1: the beat is accepted when pkt_valid and pkt_ready are both 1.
REQ-010 SHALL have ports ppi_data_lane0..3, output, 8 each: PPI lane bytes.
REQ-011 SHALL have ports ppi_lane0_en..ppi_lane3_en, output, 1 each: PPI lane enables.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on the return to IDLE.
REQ-014 SHALL have port err_underflow, output, 1: one-cycle pulse when a beat is missing in ACTIVE.

Function
REQ-015 FSM states SHALL be IDLE, PREP, ACTIVE, DRAIN.
REQ-016 IDLE: pkt_valid=1 -> PREP; N is latched from cfg_lane_cnt on this transition and held until IDLE.
REQ-017 PREP: counter runs PREP_CYCLES cycles with pkt_ready=0, then -> ACTIVE.
REQ-018 pkt_ready SHALL be 1 only in ACTIVE.
REQ-019 ACTIVE: a beat accepted in cycle t drives lane k byte/enable in cycle t+1+k (per-lane stagger of k cycles).
REQ-020 Lane enable: set only for k < N and k < pkt_nbytes of that beat; data otherwise 8'h00.
REQ-021 Lanes k >= N: enable=0, data=0 for the whole packet.
REQ-022 The first beat SHALL therefore raise lane0_en one cycle before lane1_en, lane1_en one cycle before lane2_en, and so on.
REQ-023 An accepted beat with pkt_last=1 -> DRAIN.
REQ-024 ACTIVE with pkt_valid=0 (bubble):
- pulse err_underflow;
- inject no lane data for that cycle;
- treat it as an end of packet with 0 bytes -> DRAIN.
REQ-025 DRAIN: lasts exactly N cycles with pkt_ready=0, then -> IDLE with done=1 in the first IDLE cycle.
REQ-026 pkt_nbytes of 0 or greater than N on an accepted beat SHALL be clamped to N.
REQ-027 cfg_lane_cnt changes outside IDLE SHALL have no effect.
REQ-028 IDLE->PREP SHALL NOT occur in the same cycle as done; a new packet starts no earlier than the cycle after done.

Reset
REQ-029 ppi_rst=1 at a clock edge SHALL in the next cycle:
- force IDLE;
- clear all delay stages and counters;
- drive every output to 0.
REQ-030 Reset SHALL take priority over all events, including mid-ACTIVE and mid-DRAIN; partially sent data is discarded with no done pulse.

Structure
REQ-031 A shared package ppi_pkg SHALL hold:
- the state enum;
- the lane count constant (4);
- the lane byte width (8).
REQ-032 One sub-module ppi_lane_delay (parameter DEPTH, {en,data} shift register with synchronous clear) SHALL be instantiated per lane with DEPTH=k+1.

Verification
REQ-033 Four lanes, cfg_lane_cnt=3, two beats 32'h44332211, 32'h88776655 (last), nbytes=4:
- lane0_en rises at accept+1, lane1 at +2, lane2 at +3, lane3 at +4;
- lane0 carries 11,55; lane3 carries 44,88;
- done pulses 5 cycles after the last accept.
REQ-034 One lane, cfg_lane_cnt=0, three beats:
- only lane0 toggles, carrying bytes 8'hA0,A1,A2 on consecutive cycles;
- lanes 1..3 stay 0.
REQ-035 Four lanes, last beat nbytes=2:
- lanes 0,1 enabled for that beat;
- lanes 2,3 stay disabled with data 0 in their slot.
REQ-036 Bubble after the first beat in ACTIVE:
- err_underflow pulses once;
- state goes to DRAIN, then done;
- no further pkt_ready.
REQ-037 ppi_rst asserted two cycles into ACTIVE:
- next cycle, all enables, pkt_ready and busy are 0;
- no done pulse.
REQ-038 Checker: the rise of lane0_en SHALL be followed next cycle by the rise of lane1_en whenever N>=2.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared definitions for the PPI lane scheduler.
// Holds the scheduler state encoding, the physical lane count and lane
// byte width, and the beat byte-count clamp used when accepting beats.
package ppi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREP   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } ppi_state_e;

  localparam int unsigned LANE_CNT = 4;
  localparam int unsigned LANE_W   = 8;

  // A byte count of zero or wider than the active lane set means "all lanes".
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] nbytes,
                                              input logic [2:0] lanes);
    if ((nbytes == 3'd0) || (nbytes > lanes)) begin
      return lanes;
    end else begin
      return nbytes;
    end
  endfunction

endpackage

// File: rtl/ppi_lane_delay.sv
// Per-lane delay line: a DEPTH-stage shift register of {enable, byte}.
// Ports:
//   clk_i  - clock (rising edge)
//   clr_i  - synchronous clear of every stage
//   en_i   - lane enable entering stage 0
//   data_i - lane byte entering stage 0
//   en_o   - enable leaving the last stage
//   data_o - byte leaving the last stage
module ppi_lane_delay
  import ppi_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [LANE_W-1:0] data_i,
  output logic              en_o,
  output logic [LANE_W-1:0] data_o
);

  logic [DEPTH-1:0]  en_q;
  logic [LANE_W-1:0] data_q [DEPTH];

  // Shift the {enable, byte} pair one stage per cycle, clearing on request.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        en_q[i]   <= 1'b0;
        data_q[i] <= 8'h00;
      end
    end else begin
      en_q[0]   <= en_i;
      data_q[0] <= data_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        en_q[i]   <= en_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign en_o   = en_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/ppi_lane_scheduler.sv
// PPI lane scheduler: takes packet-layer beats and spreads their bytes over
// up to four PPI lanes, lane k lagging lane 0 by k cycles.
// Sequence per packet: IDLE -> PREP (PREP_CYCLES) -> ACTIVE -> DRAIN (N) -> IDLE.
// Ports:
//   ppi_clk, ppi_rst        - clock, synchronous active-high reset
//   cfg_lane_cnt            - active lanes minus one, latched on leaving IDLE
//   pkt_valid/pkt_ready     - beat handshake (ready only in ACTIVE)
//   pkt_data/nbytes/last    - beat bytes, valid byte count, end-of-packet
//   ppi_data_laneK/laneK_en - staggered lane bytes and enables
//   busy, done, err_underflow - status: not idle, end pulse, missing beat pulse
module ppi_lane_scheduler
  import ppi_pkg::*;
#(
  parameter int unsigned PREP_CYCLES = 3
) (
  input  logic        ppi_clk,
  input  logic        ppi_rst,
  input  logic [1:0]  cfg_lane_cnt,
  input  logic        pkt_valid,
  input  logic [31:0] pkt_data,
  input  logic [2:0]  pkt_nbytes,
  input  logic        pkt_last,
  output logic        pkt_ready,
  output logic [7:0]  ppi_data_lane0,
  output logic [7:0]  ppi_data_lane1,
  output logic [7:0]  ppi_data_lane2,
  output logic [7:0]  ppi_data_lane3,
  output logic        ppi_lane0_en,
  output logic        ppi_lane1_en,
  output logic        ppi_lane2_en,
  output logic        ppi_lane3_en,
  output logic        busy,
  output logic        done,
  output logic        err_underflow
);

  localparam logic [3:0] PREP_LAST = 4'(PREP_CYCLES - 1);

  ppi_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic        ready_q, busy_q, done_q, err_q;
  logic        done_d, err_d;
  logic        accept_s;
  logic [2:0]  nbytes_s;

  logic [LANE_CNT-1:0] lane_en_in_s;
  logic [LANE_CNT-1:0] lane_en_out_s;
  logic [LANE_W-1:0]   lane_data_in_s  [LANE_CNT];
  logic [LANE_W-1:0]   lane_data_out_s [LANE_CNT];

  assign accept_s = (state_q == ST_ACTIVE) && pkt_valid;
  assign nbytes_s = clamp_nbytes(pkt_nbytes, n_q);

  // Next-state, counter and pulse logic for the packet sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The done cycle is still IDLE but may not start a new packet.
        if (pkt_valid && !done_q) begin
          state_d = ST_PREP;
          cnt_d   = 4'd0;
          n_d     = {1'b0, cfg_lane_cnt} + 3'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (cnt_q == PREP_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (pkt_valid) begin
          if (pkt_last) begin
            state_d = ST_DRAIN;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else begin
          // A bubble ends the packet as if a zero-byte last beat arrived.
          err_d   = 1'b1;
          state_d = ST_DRAIN;
          cnt_d   = 4'd0;
        end
      end
      ST_DRAIN: begin
        // N drain cycles let the slowest active lane empty its delay line.
        if (cnt_q == ({1'b0, n_q} - 4'd1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered status outputs, derived from the next state.
  always_ff @(posedge ppi_clk) begin
    if (ppi_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      n_q     <= 3'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ready_q <= (state_d == ST_ACTIVE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Lane k carries byte k of an accepted beat when k is inside both N and nbytes.
  always_comb begin
    for (int k = 0; k < int'(LANE_CNT); k++) begin
      lane_en_in_s[k]   = accept_s && (3'(k) < n_q) && (3'(k) < nbytes_s);
      lane_data_in_s[k] = lane_en_in_s[k] ? pkt_data[8*k +: 8] : 8'h00;
    end
  end

  for (genvar k = 0; k < int'(LANE_CNT); k++) begin : g_lane
    ppi_lane_delay #(
      .DEPTH (k + 1)
    ) u_delay (
      .clk_i  (ppi_clk),
      .clr_i  (ppi_rst),
      .en_i   (lane_en_in_s[k]),
      .data_i (lane_data_in_s[k]),
      .en_o   (lane_en_out_s[k]),
      .data_o (lane_data_out_s[k])
    );
  end

  assign pkt_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_underflow  = err_q;
  assign ppi_lane0_en   = lane_en_out_s[0];
  assign ppi_lane1_en   = lane_en_out_s[1];
  assign ppi_lane2_en   = lane_en_out_s[2];
  assign ppi_lane3_en   = lane_en_out_s[3];
  assign ppi_data_lane0 = lane_data_out_s[0];
  assign ppi_data_lane1 = lane_data_out_s[1];
  assign ppi_data_lane2 = lane_data_out_s[2];
  assign ppi_data_lane3 = lane_data_out_s[3];

endmodule
